// File: rtl/sensor_spi_seq.sv
// Command sequencer for the CMV300 SPI pin driver: queues register
// reads/writes and paces each one with a fixed cycle budget.
module sensor_spi_seq #(
  parameter int FIFO_AW    = 3,
  parameter int WR_CYCLES  = 20,
  parameter int RD_CYCLES  = 32,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk0,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rnw,
  input  logic [6:0]       cmd_addr,
  input  logic [7:0]       cmd_data,
  input  logic             flush,
  output logic [FIFO_AW:0] fifo_count,
  output logic             busy,
  output logic             rsp_valid,
  output logic [6:0]       rsp_addr,
  output logic [7:0]       rsp_data,
  output logic [6:0]       spi_addr,
  output logic [7:0]       spi_wr_data,
  output logic             spi_rd_en,
  output logic             spi_wr_en,
  input  logic [7:0]       spi_reg_data
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [7:0] WR_LD  = 8'(WR_CYCLES - 1);
  localparam logic [7:0] RD_LD  = 8'(RD_CYCLES - 1);
  localparam logic [7:0] GAP_LD = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPT,
    S_GAP
  } state_t;

  logic [15:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;

  state_t      r_state;
  logic        r_rnw;
  logic [7:0]  r_timer;
  logic [7:0]  r_gap;
  logic        r_rsp_pend;
  logic        r_rsp_valid;
  logic [6:0]  r_rsp_addr;
  logic [7:0]  r_rsp_data;
  logic [6:0]  r_spi_addr;
  logic [7:0]  r_spi_wdata;
  logic        r_rd_en;
  logic        r_wr_en;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [15:0] w_head;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign w_full  = r_count[FIFO_AW];
  assign w_empty = (r_count == '0);
  assign w_push  = cmd_valid & ~w_full & ~flush;
  assign w_pop   = (r_state == S_IDLE) & ~w_empty;
  assign w_head  = r_mem[r_rptr];

  always_ff @(posedge clk0) begin
    if (w_push) begin
      r_mem[r_wptr] <= {cmd_rnw, cmd_addr, cmd_data};
    end
  end

  always_ff @(posedge clk0) begin
    if (reset || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_rnw       <= 1'b0;
      r_timer     <= '0;
      r_gap       <= '0;
      r_rsp_pend  <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
      r_spi_addr  <= '0;
      r_spi_wdata <= '0;
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
    end else begin
      r_rd_en     <= 1'b0;
      r_wr_en     <= 1'b0;
      r_rsp_pend  <= 1'b0;
      r_rsp_valid <= r_rsp_pend;
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_rnw       <= w_head[15];
            r_spi_addr  <= w_head[14:8];
            r_spi_wdata <= w_head[15] ? 8'h00 : w_head[7:0];
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_rnw) begin
            r_rd_en <= 1'b1;
            r_timer <= RD_LD;
          end else begin
            r_wr_en <= 1'b1;
            r_timer <= WR_LD;
          end
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_timer == 8'd0) begin
            r_gap   <= GAP_LD;
            r_state <= r_rnw ? S_CAPT : S_GAP;
          end else begin
            r_timer <= r_timer - 8'd1;
          end
        end
        S_CAPT: begin
          r_rsp_data <= spi_reg_data;
          r_rsp_addr <= r_spi_addr;
          r_rsp_pend <= 1'b1;
          r_gap      <= GAP_LD;
          r_state    <= S_GAP;
        end
        S_GAP: begin
          if (r_gap == 8'd0) begin
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap - 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = ~w_full;
  assign fifo_count  = r_count;
  assign busy        = ~w_empty | (r_state != S_IDLE);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_addr    = r_rsp_addr;
  assign rsp_data    = r_rsp_data;
  assign spi_addr    = r_spi_addr;
  assign spi_wr_data = r_spi_wdata;
  assign spi_rd_en   = r_rd_en;
  assign spi_wr_en   = r_wr_en;

endmodule

// File: doc/sensor_spi_seq.md
Name: sensor_spi_seq

Overview:
Command sequencer that sits directly upstream of the CMV300 SPI pin driver (sensor_spi_io). It buffers register read/write commands from the control side in a small FIFO and issues them to the pin driver as single-cycle rd_en/wr_en pulses. The pin driver has no busy/done signal, so each transaction is held off for a fixed, parameterised cycle budget. For reads, it captures the returned byte and presents it with its address tag as a one-cycle response strobe.

Parameters:
FIFO_AW, 3, log2 of command FIFO depth (depth 8).
WR_CYCLES, 20, cycles from spi_wr_en pulse to end of the write transaction (range 18..255).
RD_CYCLES, 32, cycles from spi_rd_en pulse to the sample of spi_reg_data (range 30..255).
GAP_CYCLES, 2, idle cycles between consecutive transactions (range 1..255).

Ports:
clk0  in  1  clock, same 10-40 MHz clock as the pin driver.
reset  in  1  synchronous, active-high.
cmd_valid  in  1  command push request.
cmd_ready  out  1  FIFO not full; a push happens when cmd_valid & cmd_ready.
cmd_rnw  in  1  1 = read, 0 = write.
cmd_addr  in  7  sensor register address.
cmd_data  in  8  write data; ignored for reads.
flush  in  1  drops all queued (not yet issued) commands.
fifo_count  out  FIFO_AW+1  number of queued commands.
busy  out  1  high while FIFO is non-empty or the FSM is not in IDLE.
rsp_valid  out  1  one-cycle strobe when read data is captured.
rsp_addr  out  7  address of the completed read.
rsp_data  out  8  data of the completed read.
spi_addr  out  7  to pin driver addr.
spi_wr_data  out  8  to pin driver wr_data.
spi_rd_en  out  1  one-cycle read start pulse.
spi_wr_en  out  1  one-cycle write start pulse.
spi_reg_data  in  8  from pin driver reg_data.

Behaviour:
- Reset (reset=1 at the clk0 edge) applies the following values; reset mid-transaction abandons the transaction with no rsp_valid:
  - FIFO emptied; fifo_count=0; cmd_ready=1.
  - busy=0; rsp_valid=0; rsp_addr=0; rsp_data=0.
  - spi_addr=0; spi_wr_data=0; spi_rd_en=0; spi_wr_en=0.
  - FSM returns to IDLE.
- FIFO: synchronous, first-word fall-through, entry = {rnw, addr[6:0], data[7:0]} (16 bits).
  - cmd_ready = !full, registered-free (a combinational decode of the count).
  - Push while full is ignored.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Pointers wrap modulo 2^FIFO_AW.
- flush: clears FIFO pointers and fifo_count next cycle. It has priority over a same-cycle push, which is discarded. The in-flight transaction completes normally, including its rsp_valid.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head, load spi_addr/spi_wr_data (data forced to 0 for reads), go to ISSUE.
  - ISSUE (1 cycle): assert spi_rd_en or spi_wr_en for exactly this cycle; load timer with RD_CYCLES-1 or WR_CYCLES-1; go to WAIT.
  - WAIT: decrement timer. At 0: a read goes to CAPTURE, a write goes to GAP.
  - CAPTURE (1 cycle): rsp_data <= spi_reg_data, rsp_addr <= spi_addr; rsp_valid=1 the following cycle only; go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- spi_addr/spi_wr_data hold stable from ISSUE until the next IDLE pop.
- Timer: 8-bit down-counter.
- Latency:
  - Push into an empty FIFO in IDLE: spi_*_en asserts 2 cycles after the push edge.
  - Read response: rsp_valid asserts RD_CYCLES+2 cycles after spi_rd_en.
  - Back-to-back throughput: write = WR_CYCLES+GAP_CYCLES+2 cycles per command.
- Only one of spi_rd_en/spi_wr_en is ever high, and never on consecutive cycles.

Test Plan:
- After reset, push write addr=0x3A data=0x5C -> spi_wr_en single pulse 2 cycles later with spi_addr=0x3A, spi_wr_data=0x5C; busy drops after 20+2+2 cycles; no rsp_valid.
- Push read addr=0x12 with a pin-driver model returning 0xA7 -> spi_rd_en pulse; rsp_valid one cycle at 34 cycles after the pulse with rsp_addr=0x12, rsp_data=0xA7.
- Push 9 commands back-to-back while FSM busy -> cmd_ready low after 8 queued (fifo_count=8), 9th ignored; all 8 issued in order, pulses spaced 24 cycles for writes.
- Mixed sequence W(0x01,0x11), R(0x02), W(0x03,0x33), R(0x04) -> pulses in order, exactly two rsp_valid strobes tagged 0x02 then 0x04.
- Queue 5 commands, assert flush during WAIT of the first -> first completes, remaining 4 never issued, fifo_count=0 next cycle, busy low after GAP.
- Assert reset mid-WAIT of a read -> all outputs at reset values next cycle, no rsp_valid; a new push afterwards issues normally.
